// File: rtl/spi_target.sv
// SPI target (mode 0, MSB first) clocked entirely from clk_i.
// The SPI pins are oversampled through two-flop synchronisers with a third
// history flop for edge detection; SCK must not exceed clk_i/8.
// Optional build macro SPI_TARGET_RX_FIFO_EN selects a 4-entry receive FIFO;
// without it the receive side is a single holding register.
`timescale 1ns/1ps
module spi_target #(
  parameter logic [7:0] IdleByte = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       spi_sck_i,
  input  logic       spi_cs_ni,
  input  logic       spi_copi_i,
  output logic       spi_cipo_o,
  output logic       spi_cipo_en_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       overflow_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_ACTIVE    = 2'd2
  } state_e;

  // [0],[1] synchroniser stages, [2] history flop for edge detection
  logic [2:0] sck_sync_r;
  logic [2:0] cs_sync_r;
  logic [1:0] copi_sync_r;
  logic       sck_rise_r;
  logic       sck_fall_r;
  logic       cs_rise_r;
  logic       cs_fall_r;

  state_e     state_r;
  logic [1:0] settle_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] rx_shift_r;
  logic [7:0] tx_shift_r;
  logic       byte_done_r;
  logic       push_r;
  logic [7:0] push_data_r;

  logic       load_s;
  logic [7:0] load_byte_s;
  logic       pop_s;

  // Synchronise the asynchronous SPI pins and register their edge pulses
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sck_sync_r  <= 3'b000;
      cs_sync_r   <= 3'b111;
      copi_sync_r <= 2'b00;
      sck_rise_r  <= 1'b0;
      sck_fall_r  <= 1'b0;
      cs_rise_r   <= 1'b0;
      cs_fall_r   <= 1'b0;
    end else begin
      sck_sync_r  <= {sck_sync_r[1:0], spi_sck_i};
      cs_sync_r   <= {cs_sync_r[1:0], spi_cs_ni};
      copi_sync_r <= {copi_sync_r[0], spi_copi_i};
      sck_rise_r  <= sck_sync_r[1] & ~sck_sync_r[2];
      sck_fall_r  <= ~sck_sync_r[1] & sck_sync_r[2];
      cs_rise_r   <= cs_sync_r[1] & ~cs_sync_r[2];
      cs_fall_r   <= ~cs_sync_r[1] & cs_sync_r[2];
    end
  end

  // Decide whether this cycle is a transmit byte load point and what to load
  always_comb begin
    load_s      = 1'b0;
    load_byte_s = IdleByte;
    case (state_r)
      ST_IDLE:   load_s = cs_fall_r;
      ST_ACTIVE: load_s = sck_fall_r & byte_done_r & ~cs_rise_r;
      default:   load_s = 1'b0;
    endcase
    if (tx_valid_i) begin
      load_byte_s = tx_data_i;
    end else begin
      load_byte_s = IdleByte;
    end
  end

  // Transaction state machine with the receive and transmit shift registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r     <= ST_WAIT_IDLE;
      settle_r    <= 2'd0;
      bit_cnt_r   <= 3'd0;
      rx_shift_r  <= 8'h00;
      tx_shift_r  <= 8'hFF;
      byte_done_r <= 1'b0;
      push_r      <= 1'b0;
      push_data_r <= 8'h00;
    end else begin
      push_r <= 1'b0;
      case (state_r)
        ST_WAIT_IDLE: begin
          // let the synchronisers flush their reset values before trusting CS
          if (settle_r == 2'd3) begin
            if (cs_sync_r[1]) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_WAIT_IDLE;
            end
          end else begin
            settle_r <= settle_r + 2'd1;
          end
        end
        ST_IDLE: begin
          bit_cnt_r   <= 3'd0;
          byte_done_r <= 1'b0;
          if (cs_fall_r) begin
            state_r    <= ST_ACTIVE;
            tx_shift_r <= load_byte_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise_r) begin
            // a partial byte is simply dropped here
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 3'd0;
            byte_done_r <= 1'b0;
            tx_shift_r  <= 8'hFF;
          end else begin
            if (sck_rise_r) begin
              rx_shift_r <= {rx_shift_r[6:0], copi_sync_r[1]};
              bit_cnt_r  <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                push_r      <= 1'b1;
                push_data_r <= {rx_shift_r[6:0], copi_sync_r[1]};
                byte_done_r <= 1'b1;
              end
            end
            if (sck_fall_r) begin
              if (byte_done_r) begin
                tx_shift_r  <= load_byte_s;
                byte_done_r <= 1'b0;
              end else begin
                tx_shift_r <= {tx_shift_r[6:0], 1'b1};
              end
            end
          end
        end
        default: state_r <= ST_WAIT_IDLE;
      endcase
    end
  end

  // MSB of a freshly loaded byte must reach the pin in the load cycle itself
  assign spi_cipo_o    = load_s ? load_byte_s[7] : tx_shift_r[7];
  assign spi_cipo_en_o = (state_r == ST_ACTIVE);
  assign busy_o        = (state_r == ST_ACTIVE);
  assign tx_ready_o    = load_s;

`ifdef SPI_TARGET_RX_FIFO_EN
  logic [7:0] fifo_mem_r [4];
  logic [1:0] wr_ptr_r;
  logic [1:0] rd_ptr_r;
  logic [2:0] count_r;
  logic       overflow_r;
  logic       full_s;
  logic       push_ok_s;

  assign pop_s     = (count_r != 3'd0) & rx_ready_i;
  assign full_s    = (count_r == 3'd4);
  assign push_ok_s = push_r & (~full_s | pop_s);

  // Four-entry receive FIFO; a push into a full FIFO is dropped unless a pop frees room
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) begin
        fifo_mem_r[i] <= 8'h00;
      end
      wr_ptr_r   <= 2'd0;
      rd_ptr_r   <= 2'd0;
      count_r    <= 3'd0;
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= push_r & full_s & ~pop_s;
      if (push_ok_s) begin
        fifo_mem_r[wr_ptr_r] <= push_data_r;
        wr_ptr_r             <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign rx_data_o  = fifo_mem_r[rd_ptr_r];
  assign rx_valid_o = (count_r != 3'd0);
  assign overflow_o = overflow_r;
`else
  logic [7:0] hold_r;
  logic       valid_r;
  logic       overflow_r;

  assign pop_s = valid_r & rx_ready_i;

  // Single holding register; a push while still occupied and not popped is dropped
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hold_r     <= 8'h00;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= 1'b0;
      if (push_r) begin
        if (!valid_r || pop_s) begin
          hold_r  <= push_data_r;
          valid_r <= 1'b1;
        end else begin
          overflow_r <= 1'b1;
        end
      end else if (pop_s) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign rx_data_o  = hold_r;
  assign rx_valid_o = valid_r;
  assign overflow_o = overflow_r;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: a behavioural SPI host drives the
// pins, a negedge monitor records handshakes, and each scenario task compares
// against expectations computed from the transfer it generated.
`timescale 1ns/1ps
module tb_spi_target;

`ifdef SPI_TARGET_RX_FIFO_EN
  localparam int Cap = 4;
`else
  localparam int Cap = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       spi_sck_i;
  logic       spi_cs_ni;
  logic       spi_copi_i;
  logic       spi_cipo_o;
  logic       spi_cipo_en_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic       overflow_o;
  logic       busy_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] host_tx [8];
  logic [7:0] host_rx [8];
  int last_rise_cyc;
  int valid_rise_cyc;

  logic [7:0] rx_q [$];
  int tx_ready_cnt;
  int ovf_cnt;
  int valid_cycles;
  bit busy_seen;
  bit prev_valid = 1'b0;

  spi_target #(.IdleByte(8'hFF)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .spi_sck_i    (spi_sck_i),
    .spi_cs_ni    (spi_cs_ni),
    .spi_copi_i   (spi_copi_i),
    .spi_cipo_o   (spi_cipo_o),
    .spi_cipo_en_o(spi_cipo_en_o),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .tx_data_i    (tx_data_i),
    .tx_valid_i   (tx_valid_i),
    .tx_ready_o   (tx_ready_o),
    .overflow_o   (overflow_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe handshakes and pulses away from the active edge
  always @(negedge clk) begin
    if (rx_valid_o === 1'b1 && !prev_valid) valid_rise_cyc = cyc;
    prev_valid = (rx_valid_o === 1'b1);
    if (rx_valid_o === 1'b1) begin
      valid_cycles++;
      if (rx_ready_i) rx_q.push_back(rx_data_o);
    end
    if (tx_ready_o === 1'b1) tx_ready_cnt++;
    if (overflow_o === 1'b1) ovf_cnt++;
    if (busy_o === 1'b1 && spi_cipo_en_o === 1'b1) busy_seen = 1'b1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rx_q.delete();
    tx_ready_cnt   = 0;
    ovf_cnt        = 0;
    valid_cycles   = 0;
    busy_seen      = 1'b0;
    valid_rise_cyc = -1;
  endtask

  // Mode-0 host: SCK half period of 8 clk; the final SCK high phase is ended
  // only after CS has been released, so no load point follows the last byte.
  task automatic host_xfer(input int nbytes, input int last_bits);
    int nb;
    spi_cs_ni = 1'b0;
    wait_clks(8);
    for (int b = 0; b < nbytes; b++) begin
      nb = (b == nbytes - 1) ? last_bits : 8;
      host_rx[b] = 8'h00;
      for (int i = 0; i < nb; i++) begin
        spi_copi_i = host_tx[b][7-i];
        wait_clks(8);
        spi_sck_i = 1'b1;
        host_rx[b][7-i] = spi_cipo_o;
        if (i == 7) last_rise_cyc = cyc;
        wait_clks(8);
        if (!(b == nbytes - 1 && i == nb - 1)) spi_sck_i = 1'b0;
      end
    end
    spi_cs_ni = 1'b1;
    wait_clks(8);
    spi_sck_i = 1'b0;
    wait_clks(16);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    wait_clks(3);
    if (spi_cipo_o !== 1'b1) begin errors++; $display("FAIL reset_cipo: got %b expected 1", spi_cipo_o); end
    checks++;
    if (spi_cipo_en_o !== 1'b0) begin errors++; $display("FAIL reset_cipo_en: got %b expected 0", spi_cipo_en_o); end
    checks++;
    if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid_o); end
    checks++;
    if (tx_ready_o !== 1'b0) begin errors++; $display("FAIL reset_tx_ready: got %b expected 0", tx_ready_o); end
    checks++;
    if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow_o); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++;
    if (rx_data_o !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data_o); end
    checks++;
    rst_ni = 1'b1;
    wait_clks(10);
    if ({spi_cipo_o, spi_cipo_en_o, busy_o, rx_valid_o, tx_ready_o} !== 5'b10000) begin
      errors++;
      $display("FAIL post_reset_outputs: got %b expected 10000",
               {spi_cipo_o, spi_cipo_en_o, busy_o, rx_valid_o, tx_ready_o});
    end
    checks++;
  endtask

  task automatic test_basic();
    clear_mon();
    rx_ready_i = 1'b1;
    tx_valid_i = 1'b1;
    tx_data_i  = 8'hA5;
    host_tx[0] = 8'h3C;
    host_xfer(1, 8);
    if (host_rx[0] !== 8'hA5) begin errors++; $display("FAIL basic_host_rx: got %h expected a5", host_rx[0]); end
    checks++;
    if (rx_q.size() !== 1) begin errors++; $display("FAIL basic_rx_count: got %0d expected 1", rx_q.size()); end
    else if (rx_q[0] !== 8'h3C) begin errors++; $display("FAIL basic_rx_data: got %h expected 3c", rx_q[0]); end
    checks++;
    if (valid_cycles !== 1) begin errors++; $display("FAIL basic_valid_width: got %0d expected 1", valid_cycles); end
    checks++;
    if (valid_rise_cyc - last_rise_cyc !== 5) begin
      errors++;
      $display("FAIL basic_rx_latency: got %0d expected 5 cycles from SCK set to valid seen", valid_rise_cyc - last_rise_cyc);
    end
    checks++;
    if (tx_ready_cnt !== 1) begin errors++; $display("FAIL basic_tx_ready: got %0d expected 1", tx_ready_cnt); end
    checks++;
    if (busy_seen !== 1'b1) begin errors++; $display("FAIL basic_busy_seen: got %b expected 1", busy_seen); end
    checks++;
  endtask

  task automatic test_idle_byte();
    clear_mon();
    rx_ready_i = 1'b1;
    tx_valid_i = 1'b0;
    tx_data_i  = 8'h12;
    host_tx[0] = 8'($urandom);
    host_tx[1] = 8'($urandom);
    host_xfer(2, 8);
    for (int b = 0; b < 2; b++) begin
      if (host_rx[b] !== 8'hFF) begin errors++; $display("FAIL idle_host_rx[%0d]: got %h expected ff", b, host_rx[b]); end
      checks++;
    end
    if (tx_ready_cnt !== 2) begin errors++; $display("FAIL idle_tx_ready: got %0d expected 2", tx_ready_cnt); end
    checks++;
    if (rx_q.size() !== 2) begin errors++; $display("FAIL idle_rx_count: got %0d expected 2", rx_q.size()); end
    else if (rx_q[0] !== host_tx[0] || rx_q[1] !== host_tx[1]) begin
      errors++;
      $display("FAIL idle_rx_data: got %h %h expected %h %h", rx_q[0], rx_q[1], host_tx[0], host_tx[1]);
    end
    checks++;
  endtask

  task automatic test_overflow();
    clear_mon();
    rx_ready_i = 1'b0;
    tx_valid_i = 1'b1;
    tx_data_i  = 8'h00;
    for (int b = 0; b <= Cap; b++) host_tx[b] = 8'($urandom);
    host_xfer(Cap + 1, 8);
    if (ovf_cnt !== 1) begin errors++; $display("FAIL ovf_pulses: got %0d expected 1", ovf_cnt); end
    checks++;
    if (rx_valid_o !== 1'b1) begin errors++; $display("FAIL ovf_valid_held: got %b expected 1", rx_valid_o); end
    checks++;
    if (rx_data_o !== host_tx[0]) begin errors++; $display("FAIL ovf_first_kept: got %h expected %h", rx_data_o, host_tx[0]); end
    checks++;
    rx_ready_i = 1'b1;
    wait_clks(10);
    if (rx_q.size() !== Cap) begin errors++; $display("FAIL ovf_drain_count: got %0d expected %0d", rx_q.size(), Cap); end
    else begin
      for (int i = 0; i < Cap; i++) begin
        if (rx_q[i] !== host_tx[i]) begin errors++; $display("FAIL ovf_drain[%0d]: got %h expected %h", i, rx_q[i], host_tx[i]); end
        checks++;
      end
    end
    checks++;
    if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_drained_empty: got %b expected 0", rx_valid_o); end
    checks++;
  endtask

  task automatic test_partial();
    logic [7:0] t;
    clear_mon();
    rx_ready_i = 1'b1;
    t = 8'($urandom);
    tx_valid_i = 1'b1;
    tx_data_i  = t;
    host_tx[0] = 8'($urandom);
    host_xfer(1, 5);
    if (valid_cycles !== 0) begin errors++; $display("FAIL partial_no_valid: got %0d expected 0", valid_cycles); end
    checks++;
    clear_mon();
    host_tx[0] = 8'($urandom);
    host_xfer(1, 8);
    if (rx_q.size() !== 1) begin errors++; $display("FAIL partial_next_count: got %0d expected 1", rx_q.size()); end
    else if (rx_q[0] !== host_tx[0]) begin errors++; $display("FAIL partial_next_data: got %h expected %h", rx_q[0], host_tx[0]); end
    checks++;
    if (host_rx[0] !== t) begin errors++; $display("FAIL partial_next_host_rx: got %h expected %h", host_rx[0], t); end
    checks++;
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] pat [2];
    pat[0] = 8'hC3;
    pat[1] = 8'h81;
    clear_mon();
    rx_ready_i = 1'b1;
    tx_valid_i = 1'b1;
    tx_data_i  = 8'h5A;
    spi_cs_ni  = 1'b0;
    wait_clks(8);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) begin
        spi_copi_i = pat[b][7-i];
        wait_clks(8);
        spi_sck_i = 1'b1;
        if (b == 0 && i == 3) begin
          rst_ni = 1'b0;
          wait_clks(1);
          rst_ni = 1'b1;
          clear_mon();
        end
        wait_clks(8);
        spi_sck_i = 1'b0;
      end
    end
    wait_clks(8);
    if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy_o); end
    checks++;
    if (busy_seen !== 1'b0) begin errors++; $display("FAIL rst_mid_busy_seen: got %b expected 0", busy_seen); end
    checks++;
    if (valid_cycles !== 0) begin errors++; $display("FAIL rst_mid_no_rx: got %0d expected 0", valid_cycles); end
    checks++;
    if (tx_ready_cnt !== 0) begin errors++; $display("FAIL rst_mid_no_load: got %0d expected 0", tx_ready_cnt); end
    checks++;
    spi_cs_ni = 1'b1;
    wait_clks(16);
    clear_mon();
    host_tx[0] = 8'($urandom);
    host_xfer(1, 8);
    if (rx_q.size() !== 1) begin errors++; $display("FAIL rst_mid_recover_count: got %0d expected 1", rx_q.size()); end
    else if (rx_q[0] !== host_tx[0]) begin errors++; $display("FAIL rst_mid_recover_data: got %h expected %h", rx_q[0], host_tx[0]); end
    checks++;
    if (host_rx[0] !== 8'h5A) begin errors++; $display("FAIL rst_mid_recover_host_rx: got %h expected 5a", host_rx[0]); end
    checks++;
  endtask

  task automatic test_random();
    int n;
    logic [7:0] t;
    logic v;
    logic [7:0] exp_tx;
    for (int it = 0; it < 4; it++) begin
      clear_mon();
      n = $urandom_range(1, 3);
      t = 8'($urandom);
      v = 1'($urandom);
      exp_tx = v ? t : 8'hFF;
      rx_ready_i = 1'b1;
      tx_valid_i = v;
      tx_data_i  = t;
      for (int b = 0; b < n; b++) host_tx[b] = 8'($urandom);
      host_xfer(n, 8);
      if (rx_q.size() !== n) begin errors++; $display("FAIL rand%0d_rx_count: got %0d expected %0d", it, rx_q.size(), n); end
      else begin
        for (int b = 0; b < n; b++) begin
          if (rx_q[b] !== host_tx[b]) begin errors++; $display("FAIL rand%0d_rx[%0d]: got %h expected %h", it, b, rx_q[b], host_tx[b]); end
          checks++;
        end
      end
      checks++;
      for (int b = 0; b < n; b++) begin
        if (host_rx[b] !== exp_tx) begin errors++; $display("FAIL rand%0d_host_rx[%0d]: got %h expected %h", it, b, host_rx[b], exp_tx); end
        checks++;
      end
      if (tx_ready_cnt !== n) begin errors++; $display("FAIL rand%0d_tx_ready: got %0d expected %0d", it, tx_ready_cnt, n); end
      checks++;
      if (ovf_cnt !== 0) begin errors++; $display("FAIL rand%0d_no_ovf: got %0d expected 0", it, ovf_cnt); end
      checks++;
    end
  endtask

  initial begin
    rst_ni     = 1'b0;
    spi_cs_ni  = 1'b1;
    spi_sck_i  = 1'b0;
    spi_copi_i = 1'b0;
    rx_ready_i = 1'b1;
    tx_valid_i = 1'b0;
    tx_data_i  = 8'h00;
    clear_mon();
    test_reset();
    test_basic();
    test_idle_byte();
    test_overflow();
    test_partial();
    test_reset_mid_byte();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
